// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-requester bus arbiter.
package mux_arb_pkg;

  // Arbiter FSM encoding.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN_A = 2'd1,
    ARB_OWN_B = 2'd2
  } arb_state_e;

  // Mux select encoding; last_owner reuses it to name a requester.
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage : mux_arb_pkg

// File: rtl/mux_arbiter_if.sv
// Request/grant/data bundle between the two requesters and the arbiter.
// The arbiter connects through the slave modport; requesters drive the master side.
interface mux_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req_a;
  logic             req_b;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             gnt_a;
  logic             gnt_b;
  logic             sel;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             timeout;

  modport master (
    output req_a, req_b, data_a, data_b,
    input  gnt_a, gnt_b, sel, out, out_valid, timeout
  );

  modport slave (
    input  req_a, req_b, data_a, data_b,
    output gnt_a, gnt_b, sel, out, out_valid, timeout
  );
endinterface : mux_arbiter_if

// File: rtl/mux_arbiter_scale_mux.sv
// scale_mux: the shared 2:1 datapath mux whose select the arbiter owns.
module scale_mux
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  // Pure combinational select; no width conversion.
  assign y = (sel == SEL_B) ? b : a;

endmodule : scale_mux

// File: rtl/mux_arbiter.sv
// mux_arbiter: two-requester round-robin arbiter that owns the select of a
// shared scale_mux. Grants, select and out_valid are registered; out is the
// combinational mux output driven by the registered select.
// Optional forced handoff after MAX_HOLD owned cycles: define MUX_ARB_TIMEOUT_EN.
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_arbiter_if.slave  bus
);

  if (MAX_HOLD < 1) begin : g_bad_max_hold
    $error("mux_arbiter: MAX_HOLD must be >= 1");
  end

  arb_state_e state_q, state_d;
  logic       last_owner_q, last_owner_d;
  logic       sel_q, sel_d;
  logic       gnt_a_q, gnt_a_d;
  logic       gnt_b_q, gnt_b_d;
  logic       out_valid_q, out_valid_d;
  logic       hold_expired;

  // Next-state, grant and select decode for the arbitration FSM.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    state_d      = state_q;
    last_owner_d = last_owner_q;
    sel_d        = sel_q;

    case (state_q)
      ARB_IDLE: begin
        if (bus.req_a && (!bus.req_b || last_owner_q == SEL_B)) begin
          state_d = ARB_OWN_A;
        end else if (bus.req_b) begin
          state_d = ARB_OWN_B;
        end
      end
      ARB_OWN_A: begin
        if (bus.req_a && !(bus.req_b && hold_expired)) begin
          state_d = ARB_OWN_A;
        end else if (bus.req_b) begin
          state_d = ARB_OWN_B;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_OWN_B: begin
        if (bus.req_b && !(bus.req_a && hold_expired)) begin
          state_d = ARB_OWN_B;
        end else if (bus.req_a) begin
          state_d = ARB_OWN_A;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    // Entering an owned state records the owner and moves the select;
    // IDLE keeps the previous select so out does not toggle needlessly.
    if (state_d == ARB_OWN_A && state_q != ARB_OWN_A) begin
      last_owner_d = SEL_A;
      sel_d        = SEL_A;
    end else if (state_d == ARB_OWN_B && state_q != ARB_OWN_B) begin
      last_owner_d = SEL_B;
      sel_d        = SEL_B;
    end

    gnt_a_d     = (state_d == ARB_OWN_A);
    gnt_b_d     = (state_d == ARB_OWN_B);
    out_valid_d = gnt_a_d | gnt_b_d;
  end

  // FSM state and registered outputs; async reset drops any grant at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      last_owner_q <= SEL_B;
      sel_q        <= SEL_A;
      gnt_a_q      <= 1'b0;
      gnt_b_q      <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      sel_q        <= sel_d;
      gnt_a_q      <= gnt_a_d;
      gnt_b_q      <= gnt_b_d;
      out_valid_q  <= out_valid_d;
    end
  end

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             timeout_q, timeout_d;

  // Once the owner has held for MAX_HOLD cycles, a waiting peer takes over.
  assign hold_expired = (hold_cnt_q >= HOLD_LAST);

  // Hold counter: clears on any state change, counts while owned, saturates.
  // A timeout is an owner change while the old owner still requests.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_d != state_q) begin
      hold_cnt_d = '0;
    end else if (state_q != ARB_IDLE && hold_cnt_q != HOLD_MAX) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
    timeout_d = (state_q == ARB_OWN_A && state_d == ARB_OWN_B && bus.req_a) ||
                (state_q == ARB_OWN_B && state_d == ARB_OWN_A && bus.req_b);
  end

  // Hold counter and timeout pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  // Grants are held purely by req; no counter exists.
  assign hold_expired = 1'b0;
  assign bus.timeout  = 1'b0;
`endif

  assign bus.gnt_a     = gnt_a_q;
  assign bus.gnt_b     = gnt_b_q;
  assign bus.sel       = sel_q;
  assign bus.out_valid = out_valid_q;

  scale_mux #(
    .WIDTH (WIDTH)
  ) u_scale_mux (
    .sel (sel_q),
    .a   (bus.data_a),
    .b   (bus.data_b),
    .y   (bus.out)
  );

endmodule : mux_arbiter

// File: tb/tb_mux_arbiter.sv
// Scoreboard bench for mux_arbiter: each stimulus cycle pushes the expected
// post-edge outputs; a negedge monitor pops and compares them.
// Timeout expectations follow MUX_ARB_TIMEOUT_EN.
module tb_mux_arbiter;

  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;
  localparam logic [7:0] DA = 8'h3C;
  localparam logic [7:0] DB = 8'hA5;

  typedef struct {
    logic             ga;
    logic             gb;
    logic             sel;
    logic             ov;
    logic             tmo;
    logic [WIDTH-1:0] out;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  mux_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mux_arbiter #(
    .WIDTH    (WIDTH),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; expected values describe the outputs after this edge.
  task automatic cycle(input logic ra, input logic rb, input logic ega,
                       input logic egb, input logic esel, input logic etmo);
    exp_t e;
    bus.req_a  = ra;
    bus.req_b  = rb;
    bus.data_a = DA;
    bus.data_b = DB;
    @(posedge clk);
    #1;
    e.ga  = ega;
    e.gb  = egb;
    e.sel = esel;
    e.ov  = ega | egb;
    e.tmo = etmo;
    e.out = esel ? DB : DA;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt_a"},     {31'd0, bus.gnt_a},     32'd0);
    check({tag, "_gnt_b"},     {31'd0, bus.gnt_b},     32'd0);
    check({tag, "_sel"},       {31'd0, bus.sel},       32'd0);
    check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_timeout"},   {31'd0, bus.timeout},   32'd0);
  endtask

  // Monitor: compare the DUT against the oldest expectation each cycle.
  always @(negedge clk) begin
    exp_t e;
    check("mutex", {31'd0, bus.gnt_a & bus.gnt_b}, 32'd0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("gnt_a",     {31'd0, bus.gnt_a},     {31'd0, e.ga});
      check("gnt_b",     {31'd0, bus.gnt_b},     {31'd0, e.gb});
      check("sel",       {31'd0, bus.sel},       {31'd0, e.sel});
      check("out_valid", {31'd0, bus.out_valid}, {31'd0, e.ov});
      check("timeout",   {31'd0, bus.timeout},   {31'd0, e.tmo});
      check("out",       {24'd0, bus.out},       {24'd0, e.out});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    bus.req_a  = 1'b1;
    bus.req_b  = 1'b1;
    bus.data_a = DA;
    bus.data_b = DB;

    // Reset with both requesting: nothing granted.
    #1;
    check_reset_outputs("reset");
    cycle(1, 1, 0, 0, 0, 0);
    rst_n = 1'b1;

    // First tie goes to A; A holds 3 cycles, then hands to B.
    cycle(1, 1, 1, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0);
    cycle(0, 1, 0, 1, 1, 0);
    cycle(1, 1, 0, 1, 1, 0);
    // B drops while A requests: A granted directly.
    cycle(1, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // Single B pulse of 4 cycles; sel stays at B after release.
    cycle(0, 1, 0, 1, 1, 0);
    cycle(0, 1, 0, 1, 1, 0);
    cycle(0, 1, 0, 1, 1, 0);
    cycle(0, 1, 0, 1, 1, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1, 0);

    // Asynchronous reset during OWN_B clears outputs before the next edge.
    cycle(0, 1, 0, 1, 1, 0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    cycle(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // A holds while B waits: forced handoff after MAX_HOLD owned cycles.
    cycle(1, 0, 1, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0);
`ifdef MUX_ARB_TIMEOUT_EN
    cycle(1, 1, 0, 1, 1, 1);
    cycle(1, 1, 0, 1, 1, 0);
    cycle(1, 0, 1, 0, 0, 0);
`else
    cycle(1, 1, 1, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0);
`endif
    cycle(0, 0, 0, 0, 0, 0);

    // A alone keeps the bus past MAX_HOLD; a late B then preempts (macro on).
    cycle(1, 0, 1, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0);
`ifdef MUX_ARB_TIMEOUT_EN
    cycle(1, 1, 0, 1, 1, 1);
    cycle(0, 0, 0, 0, 1, 0);
`else
    cycle(1, 1, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
`endif

    // Bounded drain of any outstanding expectations.
    for (int i = 0; i < 5; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mux_arbiter
